mio_bus: RTL and testbench
==========================

# mio_bus

Data-side memory/IO bridge sitting directly downstream of the single-cycle CPU core. It consumes the core's data-port request (`CPU_MIO`, `mem_w`, `Addr_out`, `Data_out`, `dm_ctrl`), returns extended load data and the `MIO_ready` completion pulse that stalls the core. Internally it decodes the address into data RAM or memory-mapped IO. It generates byte enables and store-lane replication, handles synchronous-RAM read latency and the IO ack handshake with a timeout, and flags misaligned or unmapped accesses.

## Interface
- `RAM_AW`, 10: RAM word-address width; RAM region is byte addresses 0 .. (4<<RAM_AW)-1.
- `IO_BASE`, 32'hFFFF_0000: addresses >= IO_BASE are IO; everything between RAM top and IO_BASE is unmapped.
- `TIMEOUT`, 16: maximum cycles spent in IO_WAIT before abort (>=1).
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `cpu_req`  in  1  access request from core (`CPU_MIO`).
- `mem_w`  in  1  1 = store, 0 = load.
- `addr_in`  in  32  byte address (core `Addr_out`).
- `wdata_in`  in  32  store data (core `Data_out`).
- `dm_ctrl`  in  3  000 word, 001 half signed, 010 half unsigned, 011 byte signed, 100 byte unsigned; 101-111 illegal.
- `rdata_out`  out  32  extended load data to core `Data_in`; registered.
- `MIO_ready`  out  1  one-cycle completion pulse; registered.
- `align_err`, `bus_err`  out  1 each  one-cycle error pulses, coincident with `MIO_ready`.
- `ram_en`, `ram_we`  out  1, 4  RAM enable, byte write enables.
- `ram_addr`  out  RAM_AW  word address = addr_in[RAM_AW+1:2].
- `ram_wdata`  out  32  lane-replicated store data.
- `ram_rdata`  in  32  RAM read data, valid the cycle after `ram_en` with `ram_we`=0.
- `io_req`, `io_we`  out  1 each  IO request level, write flag.
- `io_addr`, `io_wdata`  out  32 each  IO address, replicated store data.
- `io_be`  out  4  IO byte enables.
- `io_rdata`  in  32  IO read data, valid with `io_ack`.
- `io_ack`  in  1  IO completion, sampled in IO_WAIT.

## Operation
- States: IDLE, RAM_RD, IO_WAIT, DONE.
- Core protocol: core holds all request inputs stable from `cpu_req`=1 until the cycle `MIO_ready`=1, inclusive. Requests are only sampled in IDLE.
- IDLE with `cpu_req`=1 classifies the access:
  - Illegal `dm_ctrl`, half with addr[0]=1, or word with addr[1:0]!=0: no access; register `align_err`=1 and `rdata_out`=0; go to DONE.
  - Unmapped address: no access; register `bus_err`=1 and `rdata_out`=0; go to DONE.
  - RAM store: `ram_en`=1 and `ram_we`=be, driven combinationally in this cycle; go to DONE.
  - RAM load: `ram_en`=1, `ram_we`=0; go to RAM_RD.
  - IO: latch addr, we, be and wdata; go to IO_WAIT.
- Byte enables: word 1111; half 0011 when addr[1]=0, 1100 when addr[1]=1; byte 0001<<addr[1:0].
- Store replication: byte {4{wdata[7:0]}}; half {2{wdata[15:0]}}; word unchanged.
- RAM_RD: select the lane of `ram_rdata` by addr[1:0]; sign- or zero-extend per `dm_ctrl`; register into `rdata_out`; go to DONE.
- IO_WAIT: `io_req`=1 while in this state.
  - `io_ack`=1: extend `io_rdata` as for RAM (loads only; stores leave `rdata_out` unchanged); go to DONE.
  - Counter increments each IO_WAIT cycle without ack. On reaching TIMEOUT: register `bus_err`=1 and `rdata_out`=0, drop `io_req`, go to DONE.
  - Ack on the TIMEOUT cycle counts as success.
- DONE: `MIO_ready`=1 and any error pulse for exactly this cycle; go to IDLE. The counter clears on entry to IDLE.
- Two back-to-back identical requests are two accesses: DONE never accepts a request.
- RAM outputs are 0 outside IDLE-accept cycles. IO outputs are meaningful only in IO_WAIT.

## Timing
- Reset (async, `reset`=0): state IDLE; `rdata_out`=0; `MIO_ready`, `align_err`, `bus_err`, `io_req` = 0; counter 0. Reset mid-access abandons it: `io_req` drops immediately and no `MIO_ready` is issued.
- Request first seen in cycle 0:
  - RAM store: `MIO_ready` in cycle 1.
  - Error: `MIO_ready` in cycle 1.
  - RAM load: data and `MIO_ready` in cycle 2.
  - IO with ack sampled in cycle k: `MIO_ready` in cycle k+1.
  - IO timeout: `MIO_ready` in cycle TIMEOUT+1.
- `rdata_out` holds its value until the next load or error completion.

## Test plan
- Store word 32'hDEADBEEF to 0x10, then lw 0x10 -> store `ram_we`=1111 and `MIO_ready` at cycle 1; load `rdata_out`=32'hDEADBEEF with `MIO_ready` at cycle 2.
- sb 8'h80 to 0x13, then lb and lbu 0x13 -> `ram_we`=1000, `ram_wdata`=32'h80808080; lb returns 32'hFFFFFF80; lbu returns 32'h00000080.
- lh from 0x11; lw from 0x2; `dm_ctrl`=111 -> `align_err`+`MIO_ready` at cycle 1, `ram_en` never high, `rdata_out`=0.
- lw from IO_BASE+4 with `io_ack` asserted on the 3rd IO_WAIT cycle carrying 32'h12345678 -> `io_req` high 3 cycles, `rdata_out`=32'h12345678 with `MIO_ready` the next cycle.
- IO load with `io_ack` held 0 -> `bus_err`+`MIO_ready` at cycle TIMEOUT+1 (17), `rdata_out`=0; lw from unmapped 0x8000_0000 -> `bus_err` at cycle 1.
- Assert `reset`=0 during IO_WAIT -> `io_req` falls without a clock edge, no `MIO_ready`; after release a new RAM lw completes normally.

Source files
------------

// File: rtl/mio_bus.sv
// Data-side memory/IO bridge for the single-cycle core: decodes RAM / IO / unmapped,
// builds byte enables and lane-replicated store data, and returns extended load data.

module mio_lane #(
  parameter int LANE = 0
) (
  input  logic [1:0] sz,      // 0 byte, 1 half, 2 word
  input  logic [1:0] off,
  input  logic [7:0] b_byte,
  input  logic [7:0] b_half,
  input  logic [7:0] b_word,
  output logic       be,
  output logic [7:0] wbyte
);
  localparam logic [1:0] LID = 2'(LANE);

  always_comb begin
    be    = 1'b1;
    wbyte = b_word;
    case (sz)
      2'd0: begin
        be    = (off == LID);
        wbyte = b_byte;
      end
      2'd1: begin
        be    = (off[1] == LID[1]);
        wbyte = b_half;
      end
      default: ;
    endcase
  end
endmodule

module mio_bus #(
  parameter int          RAM_AW  = 10,
  parameter logic [31:0] IO_BASE = 32'hFFFF_0000,
  parameter int          TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cpu_req,
  input  logic              mem_w,
  input  logic [31:0]       addr_in,
  input  logic [31:0]       wdata_in,
  input  logic [2:0]        dm_ctrl,
  output logic [31:0]       rdata_out,
  output logic              MIO_ready,
  output logic              align_err,
  output logic              bus_err,
  output logic              ram_en,
  output logic [3:0]        ram_we,
  output logic [RAM_AW-1:0] ram_addr,
  output logic [31:0]       ram_wdata,
  input  logic [31:0]       ram_rdata,
  output logic              io_req,
  output logic              io_we,
  output logic [31:0]       io_addr,
  output logic [31:0]       io_wdata,
  output logic [3:0]        io_be,
  input  logic [31:0]       io_rdata,
  input  logic              io_ack
);
  localparam int NUM_LANES = 4;
  localparam int CW        = $clog2(TIMEOUT + 1);
  localparam logic [32:0] RAM_TOP = 33'd4 << RAM_AW;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RAM_RD  = 2'd1;
  localparam logic [1:0] S_IO_WAIT = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;

  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [2:0]  lat_ctrl;
  logic        lat_we;
  logic [3:0]  lat_be;

  logic [1:0]                sz;
  logic [NUM_LANES-1:0]      be_w;
  logic [NUM_LANES-1:0][7:0] wlane;
  logic        align_bad, is_ram, is_io, accept, ram_hit;

  // Lane selection and sign/zero extension shared by RAM and IO loads.
  function automatic logic [31:0] extend(input logic [31:0] w, input logic [1:0] off,
                                         input logic [2:0] c);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (c)
      3'b001:  extend = {{16{h[15]}}, h};
      3'b010:  extend = {16'h0, h};
      3'b011:  extend = {{24{b[7]}}, b};
      3'b100:  extend = {24'h0, b};
      default: extend = w;
    endcase
  endfunction

  always_comb begin
    case (dm_ctrl)
      3'b000:         sz = 2'd2;
      3'b001, 3'b010: sz = 2'd1;
      default:        sz = 2'd0;
    endcase
  end

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    mio_lane #(.LANE(i)) u_lane (
      .sz     (sz),
      .off    (addr_in[1:0]),
      .b_byte (wdata_in[7:0]),
      .b_half (wdata_in[8*(i%2) +: 8]),
      .b_word (wdata_in[8*i +: 8]),
      .be     (be_w[i]),
      .wbyte  (wlane[i])
    );
  end

  always_comb begin
    align_bad = (dm_ctrl > 3'd4) ||
                ((sz == 2'd1) && addr_in[0]) ||
                ((sz == 2'd2) && (addr_in[1:0] != 2'b00));
    is_ram    = ({1'b0, addr_in} < RAM_TOP);
    is_io     = (addr_in >= IO_BASE);
    accept    = (state == S_IDLE) && cpu_req;
    ram_hit   = accept && !align_bad && is_ram;
    cnt_nxt   = cnt + CW'(1);
  end

  // RAM port is live only in the cycle a RAM access is accepted.
  always_comb begin
    ram_en    = ram_hit;
    ram_we    = (ram_hit && mem_w) ? be_w : 4'b0000;
    ram_addr  = ram_hit ? addr_in[RAM_AW+1:2] : '0;
    ram_wdata = ram_hit ? wlane : 32'h0;
  end

  always_comb begin
    io_req   = (state == S_IO_WAIT);
    io_we    = io_req & lat_we;
    io_addr  = io_req ? lat_addr : 32'h0;
    io_wdata = io_req ? lat_wdata : 32'h0;
    io_be    = io_req ? lat_be : 4'b0000;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      cnt       <= '0;
      rdata_out <= 32'h0;
      MIO_ready <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      lat_addr  <= 32'h0;
      lat_wdata <= 32'h0;
      lat_ctrl  <= 3'b000;
      lat_we    <= 1'b0;
      lat_be    <= 4'b0000;
    end else begin
      MIO_ready <= 1'b0;
      align_err <= 1'b0;
      bus_err   <= 1'b0;
      case (state)
        S_IDLE: if (accept) begin
          lat_addr  <= addr_in;
          lat_wdata <= wlane;
          lat_ctrl  <= dm_ctrl;
          lat_we    <= mem_w;
          lat_be    <= be_w;
          if (align_bad) begin
            align_err <= 1'b1;
            rdata_out <= 32'h0;
            MIO_ready <= 1'b1;
            state     <= S_DONE;
          end else if (is_ram) begin
            if (mem_w) begin
              MIO_ready <= 1'b1;
              state     <= S_DONE;
            end else begin
              state <= S_RAM_RD;
            end
          end else if (is_io) begin
            state <= S_IO_WAIT;
          end else begin
            bus_err   <= 1'b1;
            rdata_out <= 32'h0;
            MIO_ready <= 1'b1;
            state     <= S_DONE;
          end
        end
        S_RAM_RD: begin
          rdata_out <= extend(ram_rdata, lat_addr[1:0], lat_ctrl);
          MIO_ready <= 1'b1;
          state     <= S_DONE;
        end
        S_IO_WAIT: begin
          // Ack wins over timeout when both land in the same cycle.
          if (io_ack) begin
            if (!lat_we) rdata_out <= extend(io_rdata, lat_addr[1:0], lat_ctrl);
            MIO_ready <= 1'b1;
            state     <= S_DONE;
          end else if (cnt_nxt == CW'(TIMEOUT)) begin
            bus_err   <= 1'b1;
            rdata_out <= 32'h0;
            MIO_ready <= 1'b1;
            state     <= S_DONE;
          end else begin
            cnt <= cnt_nxt;
          end
        end
        default: begin
          cnt   <= '0;
          state <= S_IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_mio_bus.sv
// Directed table-driven bench for mio_bus with a behavioural word RAM and scripted IO acks.

module tb_mio_bus;
  localparam logic [31:0] IO_BASE = 32'hFFFF_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        cpu_req = 1'b0, mem_w = 1'b0;
  logic [31:0] addr_in = 32'h0, wdata_in = 32'h0;
  logic [2:0]  dm_ctrl = 3'b000;
  logic [31:0] rdata_out;
  logic        MIO_ready, align_err, bus_err;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [9:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;
  logic        io_req, io_we;
  logic [31:0] io_addr, io_wdata;
  logic [3:0]  io_be;
  logic [31:0] io_rdata = 32'h0;
  logic        io_ack = 1'b0;

  mio_bus #(.RAM_AW(10), .IO_BASE(IO_BASE), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .cpu_req(cpu_req), .mem_w(mem_w), .addr_in(addr_in),
    .wdata_in(wdata_in), .dm_ctrl(dm_ctrl), .rdata_out(rdata_out), .MIO_ready(MIO_ready),
    .align_err(align_err), .bus_err(bus_err), .ram_en(ram_en), .ram_we(ram_we),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata), .io_req(io_req),
    .io_we(io_we), .io_addr(io_addr), .io_wdata(io_wdata), .io_be(io_be),
    .io_rdata(io_rdata), .io_ack(io_ack)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:1023];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we == 4'b0000) ram_rdata <= mem[ram_addr];
      else for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
  end

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [2:0]  ctrl;
    int          ack_at;
    logic [31:0] ack_d;
    int          lat;
    logic [31:0] rdata;
    logic [3:0]  we;
    logic [31:0] rwd;
    int          en;
    logic        ae;
    logic        be;
    int          io;
    logic [3:0]  iobe;
    logic [31:0] iowd;
  } vec_t;

  localparam int NV = 23;
  vec_t tv [NV];

  int total = 0, bad = 0;
  int r_lat, r_en, r_io;
  logic [3:0]  r_we, r_iobe;
  logic [31:0] r_rwd, r_iowd;
  logic        r_ae, r_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic run(input vec_t v);
    @(posedge clk); #1;
    cpu_req = 1'b1; mem_w = v.mw; addr_in = v.addr; wdata_in = v.wd; dm_ctrl = v.ctrl;
    io_rdata = v.ack_d; io_ack = 1'b0;
    r_lat = -1; r_en = 0; r_io = 0; r_we = 4'h0; r_iobe = 4'h0;
    r_rwd = 32'h0; r_iowd = 32'h0; r_ae = 1'b0; r_be = 1'b0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (cyc > 0) begin @(posedge clk); #1; end
      io_ack = (v.ack_at > 0) && (cyc == v.ack_at);
      @(negedge clk);
      if (ram_en) begin r_en++; r_we |= ram_we; r_rwd = ram_wdata; end
      if (io_req) begin r_io++; r_iobe = io_be; r_iowd = io_wdata; end
      if (MIO_ready) begin r_lat = cyc; r_ae = align_err; r_be = bus_err; break; end
    end
    @(posedge clk); #1;
    cpu_req = 1'b0; io_ack = 1'b0;
  endtask

  task automatic check_vec(input vec_t v, input string tag);
    chk({tag, ".lat"},   32'(r_lat), 32'(v.lat));
    chk({tag, ".rdata"}, rdata_out, v.rdata);
    chk({tag, ".we"},    32'(r_we), 32'(v.we));
    chk({tag, ".rwd"},   r_rwd, v.rwd);
    chk({tag, ".en"},    32'(r_en), 32'(v.en));
    chk({tag, ".ae"},    32'(r_ae), 32'(v.ae));
    chk({tag, ".be"},    32'(r_be), 32'(v.be));
    chk({tag, ".io"},    32'(r_io), 32'(v.io));
    chk({tag, ".iobe"},  32'(r_iobe), 32'(v.iobe));
    chk({tag, ".iowd"},  r_iowd, v.iowd);
  endtask

  initial begin
    vec_t rv;
    logic [5:0] pulses;
    int npulse;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    //          mw    addr          wdata         ctrl ack ackd          lat rdata         we    rwd          en ae    be    io iobe  iowd
    tv[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 3'd0, 0, 32'h0,        1, 32'h0,        4'hF, 32'hDEADBEEF, 1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[1]  = '{1'b0, 32'h10,       32'h0,        3'd0, 0, 32'h0,        2, 32'hDEADBEEF, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[2]  = '{1'b1, 32'h13,       32'h80,       3'd3, 0, 32'h0,        1, 32'hDEADBEEF, 4'h8, 32'h80808080, 1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[3]  = '{1'b0, 32'h13,       32'h0,        3'd3, 0, 32'h0,        2, 32'hFFFFFF80, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[4]  = '{1'b0, 32'h13,       32'h0,        3'd4, 0, 32'h0,        2, 32'h00000080, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[5]  = '{1'b0, 32'h12,       32'h0,        3'd1, 0, 32'h0,        2, 32'hFFFF80AD, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[6]  = '{1'b0, 32'h10,       32'h0,        3'd2, 0, 32'h0,        2, 32'h0000BEEF, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[7]  = '{1'b1, 32'h16,       32'h1234,     3'd1, 0, 32'h0,        1, 32'h0000BEEF, 4'hC, 32'h12341234, 1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[8]  = '{1'b0, 32'h14,       32'h0,        3'd0, 0, 32'h0,        2, 32'h12340000, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[9]  = '{1'b0, 32'h11,       32'h0,        3'd1, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b1, 1'b0, 0, 4'h0, 32'h0};
    tv[10] = '{1'b0, 32'h10,       32'h0,        3'd0, 0, 32'h0,        2, 32'h80ADBEEF, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[11] = '{1'b0, 32'h2,        32'h0,        3'd0, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b1, 1'b0, 0, 4'h0, 32'h0};
    tv[12] = '{1'b0, 32'h10,       32'h0,        3'd7, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b1, 1'b0, 0, 4'h0, 32'h0};
    tv[13] = '{1'b0, 32'h10,       32'h0,        3'd0, 0, 32'h0,        2, 32'h80ADBEEF, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[14] = '{1'b0, 32'h80000000, 32'h0,        3'd0, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1, 0, 4'h0, 32'h0};
    tv[15] = '{1'b1, 32'hFFC,      32'hCAFEF00D, 3'd0, 0, 32'h0,        1, 32'h0,        4'hF, 32'hCAFEF00D, 1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[16] = '{1'b0, 32'hFFC,      32'h0,        3'd0, 0, 32'h0,        2, 32'hCAFEF00D, 4'h0, 32'h0,        1, 1'b0, 1'b0, 0, 4'h0, 32'h0};
    tv[17] = '{1'b0, 32'h1000,     32'h0,        3'd0, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1, 0, 4'h0, 32'h0};
    tv[18] = '{1'b0, 32'hFFFEFFFC, 32'h0,        3'd0, 0, 32'h0,        1, 32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1, 0, 4'h0, 32'h0};
    tv[19] = '{1'b0, 32'hFFFF0004, 32'h0,        3'd0, 3, 32'h12345678, 4, 32'h12345678, 4'h0, 32'h0,        0, 1'b0, 1'b0, 3, 4'hF, 32'h0};
    tv[20] = '{1'b1, 32'hFFFF0002, 32'hAB,       3'd4, 1, 32'hFFFFFFFF, 2, 32'h12345678, 4'h0, 32'h0,        0, 1'b0, 1'b0, 1, 4'h4, 32'hABABABAB};
    tv[21] = '{1'b0, 32'hFFFF0000, 32'h0,        3'd0, 0, 32'h0,       17, 32'h0,        4'h0, 32'h0,        0, 1'b0, 1'b1, 16, 4'hF, 32'h0};
    tv[22] = '{1'b0, 32'hFFFF0008, 32'h0,        3'd0, 16, 32'h5A5A5A5A, 17, 32'h5A5A5A5A, 4'h0, 32'h0,     0, 1'b0, 1'b0, 16, 4'hF, 32'h0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.rdata", rdata_out, 32'h0);
    chk("rst.ready", 32'(MIO_ready), 32'h0);
    chk("rst.io_req", 32'(io_req), 32'h0);
    reset = 1'b1;
    chk("idle.ram_en", 32'(ram_en), 32'h0);

    for (int i = 0; i < NV; i++) begin
      run(tv[i]);
      check_vec(tv[i], $sformatf("v%0d", i));
    end

    // Held identical request: two full accesses, DONE must not accept.
    @(posedge clk); #1;
    cpu_req = 1'b1; mem_w = 1'b0; addr_in = 32'h14; dm_ctrl = 3'd0; wdata_in = 32'h0;
    pulses = 6'h0; npulse = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin @(posedge clk); #1; end
      @(negedge clk);
      pulses[c] = MIO_ready;
      if (ram_en) npulse++;
    end
    @(posedge clk); #1; cpu_req = 1'b0;
    chk("b2b.ready_pattern", 32'(pulses), 32'h24);
    chk("b2b.ram_en_count", 32'(npulse), 32'd2);
    chk("b2b.rdata", rdata_out, 32'h12340000);

    // Reset during IO_WAIT drops io_req asynchronously and abandons the access.
    @(posedge clk); #1;
    cpu_req = 1'b1; mem_w = 1'b0; addr_in = IO_BASE; dm_ctrl = 3'd0; io_ack = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rstio.io_req_before", 32'(io_req), 32'h1);
    #2 reset = 1'b0;
    #1;
    chk("rstio.io_req_async", 32'(io_req), 32'h0);
    cpu_req = 1'b0;
    npulse = 0;
    repeat (3) begin @(negedge clk); if (MIO_ready) npulse++; end
    reset = 1'b1;
    repeat (3) begin @(negedge clk); if (MIO_ready) npulse++; end
    chk("rstio.no_ready", 32'(npulse), 32'h0);
    chk("rstio.rdata", rdata_out, 32'h0);

    rv = tv[13];
    run(rv);
    check_vec(rv, "post_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
